// File: rtl/param_cb_cfg.sv
// Connection block: W-track channel to K logic-block inputs, driven back by clb_out.
// Serial shadow config chain, applied atomically on a length-checked commit.
module param_cb_cfg #(
    parameter int W       = 4,
    parameter int K       = 4,
    parameter int REG_OUT = 0
) (
    input  logic         clb_clk,
    input  logic         clb_rst,
    input  logic         cfg_en,
    input  logic         cfg_din,
    input  logic         cfg_commit,
    output logic         cfg_dout,
    output logic         cfg_done,
    output logic         cfg_err,
    input  logic [W-1:0] track_in,
    output logic [W-1:0] track_out,
    output logic [K-1:0] clb_in,
    input  logic         clb_out
);
    localparam int SEL_W    = ($clog2(2 * W) < 1) ? 1 : $clog2(2 * W);
    localparam int CFG_BITS = K * SEL_W + W;
    localparam int CNT_W    = $clog2(CFG_BITS + 2);
    localparam int CAND_N   = 1 << SEL_W;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(CFG_BITS + 1);

    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [W-1:0]        drive;
    logic [W-1:0]        t;
    logic [CAND_N-1:0]   cand;

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        err_d    = err_q;
        if (cfg_commit) begin
            cnt_d = '0;
            if (cnt_q == CNT_FULL) begin
                active_d = shadow_q;
                done_d   = 1'b1;
                err_d    = 1'b0;
            end else begin
                done_d = 1'b0;
                err_d  = 1'b1;
            end
        end else if (cfg_en) begin
            shadow_d = {shadow_q[CFG_BITS-2:0], cfg_din};
            done_d   = 1'b0;
            // Saturate one past full so an over-long load can never commit
            if (cnt_q != CNT_OVF) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clb_clk) begin
        if (clb_rst) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cfg_dout = shadow_q[CFG_BITS-1];
    assign cfg_done = done_q;
    assign cfg_err  = err_q;
    assign drive    = active_q[W-1:0];

    always_comb begin
        t = '0;
        for (int i = 0; i < W; i++) begin
            t[i] = drive[i] ? clb_out : track_in[i];
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            logic [W-1:0] tout_q, tout_d;

            assign tout_d = t;

            always_ff @(posedge clb_clk) begin
                if (clb_rst) begin
                    tout_q <= '0;
                end else begin
                    tout_q <= tout_d;
                end
            end

            assign track_out = tout_q;
        end else begin : g_comb
            assign track_out = t;
        end
    endgenerate

    // Candidates padded to 2**SEL_W with zeros, so out-of-range selects read 0
    always_comb begin
        cand = '0;
        for (int i = 0; i < W; i++) begin
            cand[2*i]   = track_out[i];
            cand[2*i+1] = track_in[i];
        end
    end

    always_comb begin
        clb_in = '0;
        for (int k = 0; k < K; k++) begin
            clb_in[k] = cand[active_q[W+SEL_W*k +: SEL_W]];
        end
    end

endmodule

// File: tb/tb_param_cb_cfg.sv
// Bench for param_cb_cfg: two chained W=4/K=4 combinational blocks
// and one W=3/K=2 registered block, checked through an expectation queue.
module tb_param_cb_cfg;
    logic clk = 1'b0;
    logic rst;

    logic       en_a, din_a, commit_a, dout_a, done_a, err_a, co_a;
    logic [3:0] ti_a, to_a, ci_a;
    logic       en_b, commit_b, dout_b, done_b, err_b;
    logic [3:0] to_b, ci_b;
    logic       en_r, din_r, commit_r, dout_r, done_r, err_r, co_r;
    logic [2:0] ti_r, to_r;
    logic [1:0] ci_r;

    int total = 0;
    int bad   = 0;

    logic [9:0] sb[$];
    logic [4:0] sb_r[$];

    always #5 clk = ~clk;

    param_cb_cfg #(.W(4), .K(4), .REG_OUT(0)) dut_a (
        .clb_clk(clk), .clb_rst(rst), .cfg_en(en_a), .cfg_din(din_a),
        .cfg_commit(commit_a), .cfg_dout(dout_a), .cfg_done(done_a),
        .cfg_err(err_a), .track_in(ti_a), .track_out(to_a),
        .clb_in(ci_a), .clb_out(co_a)
    );

    param_cb_cfg #(.W(4), .K(4), .REG_OUT(0)) dut_b (
        .clb_clk(clk), .clb_rst(rst), .cfg_en(en_b), .cfg_din(dout_a),
        .cfg_commit(commit_b), .cfg_dout(dout_b), .cfg_done(done_b),
        .cfg_err(err_b), .track_in(ti_a), .track_out(to_b),
        .clb_in(ci_b), .clb_out(co_a)
    );

    param_cb_cfg #(.W(3), .K(2), .REG_OUT(1)) dut_r (
        .clb_clk(clk), .clb_rst(rst), .cfg_en(en_r), .cfg_din(din_r),
        .cfg_commit(commit_r), .cfg_dout(dout_r), .cfg_done(done_r),
        .cfg_err(err_r), .track_in(ti_r), .track_out(to_r),
        .clb_in(ci_r), .clb_out(co_r)
    );

    function automatic logic [7:0] drv(int w, logic [31:0] act,
                                       logic [7:0] ti, logic co);
        logic [7:0] r = '0;
        for (int i = 0; i < w; i++) r[i] = act[i] ? co : ti[i];
        return r;
    endfunction

    function automatic logic [7:0] clbm(int w, int k, int sw, logic [31:0] act,
                                        logic [7:0] ti, logic [7:0] tout);
        logic [7:0] r = '0;
        int sel;
        for (int j = 0; j < k; j++) begin
            sel = int'((act >> (w + sw * j)) & ((32'd1 << sw) - 32'd1));
            if (sel < 2 * w) r[j] = (sel % 2 == 1) ? ti[sel/2] : tout[sel/2];
        end
        return r;
    endfunction

    function automatic logic [9:0] exp4(logic [15:0] act, logic [3:0] ti,
                                        logic co, logic d, logic e);
        logic [7:0] t, c;
        t = drv(4, {16'h0, act}, {4'h0, ti}, co);
        c = clbm(4, 4, 3, {16'h0, act}, {4'h0, ti}, t);
        return {c[3:0], t[3:0], d, e};
    endfunction

    task automatic shift_a(input logic [31:0] data, input int n, input logic both);
        for (int i = n - 1; i >= 0; i--) begin
            din_a = data[i];
            en_a  = 1'b1;
            en_b  = both;
            @(posedge clk);
            #1;
        end
        en_a = 1'b0;
        en_b = 1'b0;
    endtask

    task automatic commit_a_b(input logic ca, input logic cb);
        commit_a = ca;
        commit_b = cb;
        @(posedge clk);
        #1;
        commit_a = 1'b0;
        commit_b = 1'b0;
    endtask

    task automatic test_reset;
        logic [9:0] e;
        logic [9:0] got;
        rst = 1'b1; en_a = 1'b1; commit_a = 1'b1; din_a = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; en_a = 1'b0; commit_a = 1'b0; din_a = 1'b0;
        ti_a = 4'b1010; co_a = 1'b1;
        sb.push_back(10'b0000_1010_0_0);
        #1;
        got = {ci_a, to_a, done_a, err_a};
        e = sb.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL reset got=%b exp=%b", got, e);
        end
    endtask

    task automatic test_load;
        logic [9:0] e;
        logic [9:0] got;
        shift_a(32'hE935, 16, 1'b0);
        commit_a_b(1'b1, 1'b0);
        ti_a = 4'b0010; co_a = 1'b1;
        sb.push_back(exp4(16'hE935, ti_a, co_a, 1'b1, 1'b0));
        #1;
        got = {ci_a, to_a, done_a, err_a};
        e = sb.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL load_fixed got=%b exp=%b", got, e);
        end
        for (int p = 0; p < 4; p++) begin
            ti_a = 4'($urandom_range(0, 15));
            co_a = 1'($urandom_range(0, 1));
            sb.push_back(exp4(16'hE935, ti_a, co_a, 1'b1, 1'b0));
            #1;
            got = {ci_a, to_a, done_a, err_a};
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL load_rand%0d ti=%b co=%b got=%b exp=%b",
                         p, ti_a, co_a, got, e);
            end
        end
    endtask

    task automatic test_short;
        logic [9:0] e;
        logic [9:0] got;
        ti_a = 4'b0110; co_a = 1'b1;
        shift_a(32'h1234, 15, 1'b0);
        sb.push_back(exp4(16'hE935, ti_a, co_a, 1'b0, 1'b0));
        got = {ci_a, to_a, done_a, err_a};
        e = sb.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL shift_clears_done got=%b exp=%b", got, e);
        end
        commit_a_b(1'b1, 1'b0);
        sb.push_back(exp4(16'hE935, ti_a, co_a, 1'b0, 1'b1));
        got = {ci_a, to_a, done_a, err_a};
        e = sb.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL short_commit got=%b exp=%b", got, e);
        end
        shift_a(32'h32E3, 16, 1'b0);
        commit_a_b(1'b1, 1'b0);
        ti_a = 4'b1001; co_a = 1'b0;
        sb.push_back(exp4(16'h32E3, ti_a, co_a, 1'b1, 1'b0));
        #1;
        got = {ci_a, to_a, done_a, err_a};
        e = sb.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL recover_commit got=%b exp=%b", got, e);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] e;
        logic [9:0] got;
        shift_a(32'h05F8, 16, 1'b0);
        en_a = 1'b1; din_a = 1'b1;
        commit_a_b(1'b1, 1'b0);
        en_a = 1'b0;
        ti_a = 4'b0101; co_a = 1'b1;
        sb.push_back(exp4(16'h05F8, ti_a, co_a, 1'b1, 1'b0));
        #1;
        got = {ci_a, to_a, done_a, err_a};
        e = sb.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL en_with_commit got=%b exp=%b", got, e);
        end
        shift_a(32'hE935, 16, 1'b0);
        commit_a_b(1'b1, 1'b0);
        sb.push_back(exp4(16'hE935, ti_a, co_a, 1'b1, 1'b0));
        got = {ci_a, to_a, done_a, err_a};
        e = sb.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL count_zeroed got=%b exp=%b", got, e);
        end
        shift_a(32'h1_05F8, 17, 1'b0);
        commit_a_b(1'b1, 1'b0);
        sb.push_back(exp4(16'hE935, ti_a, co_a, 1'b0, 1'b1));
        got = {ci_a, to_a, done_a, err_a};
        e = sb.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL overflow_commit got=%b exp=%b", got, e);
        end
    endtask

    task automatic test_chain;
        logic [9:0] e;
        logic [9:0] got;
        shift_a(32'h32E3, 16, 1'b0);
        commit_a_b(1'b1, 1'b0);
        shift_a(32'h05F8, 16, 1'b1);
        commit_a_b(1'b1, 1'b1);
        ti_a = 4'b1100; co_a = 1'b1;
        sb.push_back(exp4(16'h05F8, ti_a, co_a, 1'b1, 1'b0));
        sb.push_back(exp4(16'h32E3, ti_a, co_a, 1'b1, 1'b0));
        #1;
        got = {ci_a, to_a, done_a, err_a};
        e = sb.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL chain_first got=%b exp=%b", got, e);
        end
        got = {ci_b, to_b, done_b, err_b};
        e = sb.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL chain_second got=%b exp=%b", got, e);
        end
    endtask

    task automatic test_regout;
        logic [8:0] cfg_r = 9'b000_110_111;
        logic [7:0] prev;
        logic [7:0] c;
        logic [4:0] e;
        logic [4:0] got;
        logic       pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        ti_r = 3'b010; co_r = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din_r = 1'b1; en_r = 1'b1;
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 8; i >= 0; i--) begin
            din_r = cfg_r[i]; en_r = 1'b1;
            @(posedge clk);
            #1;
        end
        en_r = 1'b0;
        commit_r = 1'b1;
        @(posedge clk);
        #1;
        commit_r = 1'b0;
        total++;
        if ({done_r, err_r} !== 2'b10) begin
            bad++;
            $display("FAIL reg_commit_after_rst got=%b exp=10", {done_r, err_r});
        end
        @(posedge clk);
        #1;
        prev = drv(3, {23'h0, cfg_r}, {5'h0, ti_r}, co_r);
        for (int p = 0; p < 5; p++) begin
            co_r = pat[p];
            c = clbm(3, 2, 3, {23'h0, cfg_r}, {5'h0, ti_r}, prev);
            sb_r.push_back({c[1:0], prev[2:0]});
            #1;
            got = {ci_r, to_r};
            e = sb_r.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL reg_hold%0d got=%b exp=%b", p, got, e);
            end
            @(posedge clk);
            #1;
            prev = drv(3, {23'h0, cfg_r}, {5'h0, ti_r}, co_r);
            c = clbm(3, 2, 3, {23'h0, cfg_r}, {5'h0, ti_r}, prev);
            sb_r.push_back({c[1:0], prev[2:0]});
            got = {ci_r, to_r};
            e = sb_r.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL reg_follow%0d got=%b exp=%b", p, got, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en_a = 1'b0; din_a = 1'b0; commit_a = 1'b0; ti_a = '0; co_a = 1'b0;
        en_b = 1'b0; commit_b = 1'b0;
        en_r = 1'b0; din_r = 1'b0; commit_r = 1'b0; ti_r = '0; co_r = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load();
        test_short();
        test_back_to_back();
        test_chain();
        test_regout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
